sram_like_arbiter: RTL and testbench
====================================

// Module: sram_like_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the instruction-side and data-side SRAM-like requesters
//  that leave the core (inst_sram_* / data_sram_* after the I/D caches). It arbitrates the address
//  phase, holds a grant until addr_ok, and records the issuing master per accepted request in an
//  in-order ID FIFO. Each mem data_ok/rdata is routed back to the master at the FIFO head.
// PARAMETERS
//  CMD_W        71  packed command width {wr[1],size[2],wstrb[4],addr[32],wdata[32]}
//  DATA_W       32  read data width
//  DEPTH         4  max outstanding accepted-but-unanswered requests (power of 2, >=2)
//  STARVE_LIM    3  consecutive data grants allowed while inst_req waits before inst is forced
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst_n          in   1       synchronous, active-low reset
//  inst_req       in   1       inst master request, held until inst_addr_ok
//  inst_cmd       in   CMD_W   inst packed command, stable while inst_req=1
//  inst_addr_ok   out  1       inst address phase accepted
//  inst_data_ok   out  1       inst response valid
//  inst_rdata     out  DATA_W  inst response data
//  data_req       in   1       data master request, held until data_addr_ok
//  data_cmd       in   CMD_W   data packed command
//  data_addr_ok   out  1       data address phase accepted
//  data_data_ok   out  1       data response valid (reads and write acks)
//  data_rdata     out  DATA_W  data response data
//  mem_req        out  1       shared port request
//  mem_cmd        out  CMD_W   shared port command = granted master's cmd
//  mem_addr_ok    in   1       shared port address accept
//  mem_data_ok    in   1       shared port response, strictly in request order
//  mem_rdata      in   DATA_W  shared port response data
//  outstanding_o  out  $clog2(DEPTH+1)  current FIFO occupancy
//  err_o          out  1       sticky: mem_data_ok seen with empty FIFO
// BEHAVIOUR
//  Reset (rst_n=0 at edge): grant state IDLE, FIFO empty, ptrs=0, starve_cnt=0, err_o=0.
//   Outputs then: all *_addr_ok/*_data_ok=0, mem_req=0, outstanding_o=0. mem side is reset in same cycle.
//  Grant FSM: IDLE, LOCK_I, LOCK_D. Winner is chosen combinationally in IDLE.
//   IDLE: no winner if FIFO full. Otherwise data wins over inst, except inst wins when
//   starve_cnt==STARVE_LIM and inst_req=1.
//   mem_req=winner req; mem_cmd=winner cmd (mux, 0 when none).
//   Winner issued, mem_addr_ok=0 -> LOCK_<winner>. Winner keeps the port with no re-arbitration.
//   LOCK_x: mem_req=x_req, mem_cmd=x_cmd, FIFO full ignored (slot reserved at lock entry).
//   mem_addr_ok=1 -> IDLE.
//   x_addr_ok = mem_addr_ok & mem_req & (granted==x); same cycle, zero added latency.
//   The non-granted master never sees addr_ok.
//  Accept (mem_req & mem_addr_ok): push granted ID (0=inst,1=data) at wr_ptr.
//  Response (mem_data_ok): pop head. inst_data_ok/data_data_ok = mem_data_ok & (head==ID).
//   Both rdata outputs = mem_rdata. Same-cycle passthrough, no added latency.
//  Push+pop in one cycle: count unchanged, both ptrs advance; legal at full and at empty+1.
//  mem_data_ok with FIFO empty: no pop, no master data_ok, err_o<=1 until reset.
//  Ptrs are log2(DEPTH) bits and wrap naturally. count is 0..DEPTH.
//  starve_cnt: cleared on any inst accept or when inst_req=0.
//   +1 (saturating at STARVE_LIM) on each data accept while inst_req=1.
//  Reset mid-transaction discards locks and outstanding IDs; in-flight data_ok is not delivered.
// STRUCTURE
//  Shared header: ARB_ID_INST/ARB_ID_DATA, CMD field offsets (`CmdWrBit, `CmdAddrRange...),
//   FSM state encodings; added alongside existing bus-width defines.
//  Sub-module: sram_like_id_fifo (1-bit wide, DEPTH entries, push/pop/full/empty/count).
//  Grant FSM + starvation counter + muxes in this module.
// TESTING
//  Only inst_req, addr 0x1c000000, mem_addr_ok same cycle, data_ok 2 cyc later
//   -> inst_addr_ok at T0, inst_data_ok at T2, data_data_ok never.
//  inst_req and data_req together at T0 -> data granted, mem_cmd=data_cmd.
//   inst accepted on the next free cycle; responses routed in that order.
//  data_req continuously, inst_req held, STARVE_LIM=3 -> after 3 data accepts, 4th grant is inst.
//  mem_addr_ok low 3 cycles with inst granted, data_req rises at T1 -> mem_cmd stays inst_cmd until accept.
//  Accept 4 with no data_ok -> outstanding_o=4, mem_req=0, no addr_ok.
//   Then one data_ok -> count 3, next request accepted.
//  mem_data_ok with empty FIFO -> err_o=1 and stays 1. rst_n=0 one cycle -> err_o=0, outstanding_o=0.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter_pkg
// Shared definitions for the SRAM-like port arbiter: master IDs stored in the
// in-order ID FIFO, bit offsets of the packed command word
// {wr[1], size[2], wstrb[4], addr[32], wdata[32]} and the grant FSM states.
// No ports (package only).
// ---------------------------------------------------------------------------
package sram_like_arbiter_pkg;

  // Master IDs as recorded in the outstanding-request FIFO
  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  // Field offsets inside the 71-bit packed command
  localparam int CMD_WDATA_LSB = 0;
  localparam int CMD_ADDR_LSB  = 32;
  localparam int CMD_WSTRB_LSB = 64;
  localparam int CMD_SIZE_LSB  = 68;
  localparam int CMD_WR_BIT    = 70;

  // Grant FSM: IDLE arbitrates, LOCK_x holds the port for master x until addr_ok
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } arbState_t;

  // Lock state matching a granted master ID
  function automatic arbState_t lockStateFor(input logic id);
    return (id == ARB_ID_INST) ? ST_LOCK_I : ST_LOCK_D;
  endfunction

  // Address field of a packed command
  function automatic logic [31:0] cmdAddr(input logic [70:0] cmd);
    return cmd[CMD_ADDR_LSB +: 32];
  endfunction

  // Write flag of a packed command
  function automatic logic cmdIsWrite(input logic [70:0] cmd);
    return cmd[CMD_WR_BIT];
  endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// ---------------------------------------------------------------------------
// sram_like_id_fifo
// In-order FIFO of 1-bit master IDs, one entry per accepted-but-unanswered
// request on the shared memory port. Push and pop in the same cycle are legal
// at any occupancy, including full and empty+1.
// Ports:
//   clk       in   clock
//   rst_n     in   synchronous active-low reset (empties the FIFO)
//   i_push    in   write i_pushId at the tail
//   i_pushId  in   ID to record
//   i_pop     in   drop the head entry
//   o_headId  out  ID at the head
//   o_full    out  DEPTH entries held
//   o_empty   out  no entries held
//   o_count   out  occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module sram_like_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic                         i_pushId,
  input  logic                         i_pop,
  output logic                         o_headId,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  // A push at full is only taken when a pop frees the head slot in the same
  // cycle; a pop at empty is dropped.
  always_comb begin
    w_doPush = i_push & (~o_full | i_pop);
    w_doPop  = i_pop & ~o_empty;
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushId;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; the count moves
  // only when exactly one of push/pop happens.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Status outputs straight from the registered state
  always_comb begin
    o_headId = r_mem[r_rdPtr];
    o_full   = (r_count == CNT_FULL);
    o_empty  = (r_count == '0);
    o_count  = r_count;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter
// Shares one SRAM-like memory port between the instruction and data masters.
// The address phase is arbitrated (data first, inst forced after STARVE_LIM
// consecutive data grants while inst waits); a granted master keeps the port
// until mem_addr_ok. Every accepted request logs its master in an in-order ID
// FIFO and each mem_data_ok is steered to the master at the FIFO head.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   inst_req/inst_cmd                  inst master address phase
//   inst_addr_ok/data_ok/rdata         inst master handshakes and read data
//   data_req/data_cmd                  data master address phase
//   data_addr_ok/data_ok/rdata         data master handshakes and read data
//   mem_req/mem_cmd                    shared port request and command
//   mem_addr_ok/data_ok/rdata          shared port handshakes and read data
//   outstanding_o                      FIFO occupancy
//   err_o                              sticky: response arrived with no request
// ---------------------------------------------------------------------------
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int CMD_W      = 71,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        inst_req,
  input  logic [CMD_W-1:0]            inst_cmd,
  output logic                        inst_addr_ok,
  output logic                        inst_data_ok,
  output logic [DATA_W-1:0]           inst_rdata,
  input  logic                        data_req,
  input  logic [CMD_W-1:0]            data_cmd,
  output logic                        data_addr_ok,
  output logic                        data_data_ok,
  output logic [DATA_W-1:0]           data_rdata,
  output logic                        mem_req,
  output logic [CMD_W-1:0]            mem_cmd,
  input  logic                        mem_addr_ok,
  input  logic                        mem_data_ok,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [$clog2(DEPTH+1)-1:0]  outstanding_o,
  output logic                        err_o
);

  localparam int SC_W = $clog2(STARVE_LIM + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);
  localparam logic [SC_W-1:0] SC_ONE     = SC_W'(1);

  arbState_t                     r_state;
  logic [SC_W-1:0]               r_starveCnt;
  logic                          r_err;
  logic                          w_grantValid;
  logic                          w_grantId;
  logic                          w_accept;
  logic                          w_pop;
  logic                          w_fifoFull;
  logic                          w_fifoEmpty;
  logic                          w_headId;
  logic [$clog2(DEPTH+1)-1:0]    w_count;

  // Pick who owns the port this cycle. In IDLE nobody may start while the
  // FIFO is full; inside a lock the slot was already free at lock entry and
  // nothing else can be accepted meanwhile, so fullness is not rechecked.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantId    = ARB_ID_DATA;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifoFull) begin
          if (inst_req && (!data_req || (r_starveCnt == STARVE_MAX))) begin
            w_grantValid = 1'b1;
            w_grantId    = ARB_ID_INST;
          end else if (data_req) begin
            w_grantValid = 1'b1;
            w_grantId    = ARB_ID_DATA;
          end
        end
      end
      ST_LOCK_I: begin
        w_grantValid = 1'b1;
        w_grantId    = ARB_ID_INST;
      end
      ST_LOCK_D: begin
        w_grantValid = 1'b1;
        w_grantId    = ARB_ID_DATA;
      end
      default: begin
        w_grantValid = 1'b0;
        w_grantId    = ARB_ID_DATA;
      end
    endcase
  end

  // Drive the shared port from the granted master and pass handshakes back
  // in the same cycle. Responses go to whoever sits at the FIFO head; a
  // response with an empty FIFO is dropped (and flagged below).
  always_comb begin
    mem_req = 1'b0;
    mem_cmd = '0;
    if (w_grantValid) begin
      mem_req = (w_grantId == ARB_ID_INST) ? inst_req : data_req;
      mem_cmd = (w_grantId == ARB_ID_INST) ? inst_cmd : data_cmd;
    end
    w_accept     = mem_req & mem_addr_ok;
    inst_addr_ok = w_accept & (w_grantId == ARB_ID_INST);
    data_addr_ok = w_accept & (w_grantId == ARB_ID_DATA);
    w_pop        = mem_data_ok & ~w_fifoEmpty;
    inst_data_ok = w_pop & (w_headId == ARB_ID_INST);
    data_data_ok = w_pop & (w_headId == ARB_ID_DATA);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    outstanding_o = w_count;
    err_o        = r_err;
  end

  // Grant FSM: a winner that is not accepted immediately locks the port so
  // its command stays on mem_cmd until the memory takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grantValid && !mem_addr_ok) begin
            r_state <= lockStateFor(w_grantId);
          end
        end
        ST_LOCK_I, ST_LOCK_D: begin
          if (w_accept) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Count data accepts that overtook a waiting inst request. Saturates at the
  // limit, at which point IDLE arbitration hands the port to inst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starveCnt <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      r_starveCnt <= '0;
    end else if (data_addr_ok && (r_starveCnt != STARVE_MAX)) begin
      r_starveCnt <= r_starveCnt + SC_ONE;
    end
  end

  // Sticky error for a response that has no matching request on record.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (mem_data_ok && w_fifoEmpty) begin
      r_err <= 1'b1;
    end
  end

  sram_like_id_fifo #(
    .DEPTH (DEPTH)
  ) u_idFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_accept),
    .i_pushId (w_grantId),
    .i_pop    (w_pop),
    .o_headId (w_headId),
    .o_full   (w_fifoFull),
    .o_empty  (w_fifoEmpty),
    .o_count  (w_count)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_like_arbiter
// Directed vectors for the SRAM-like arbiter. Each vector drives one cycle of
// master/memory inputs and holds the hand-computed outputs expected before
// the next rising edge.
// ---------------------------------------------------------------------------
module tb_sram_like_arbiter;

  localparam int CMD_W      = 71;
  localparam int DATA_W     = 32;
  localparam int DEPTH      = 4;
  localparam int STARVE_LIM = 3;

  localparam logic [CMD_W-1:0] INST_CMD = {1'b0, 2'd2, 4'hf, 32'h1c00_0000, 32'h0000_0000};
  localparam logic [CMD_W-1:0] DATA_CMD = {1'b1, 2'd2, 4'hf, 32'h1c00_1000, 32'hdead_beef};

  logic              clk;
  logic              rst_n;
  logic              inst_req;
  logic [CMD_W-1:0]  inst_cmd;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req;
  logic [CMD_W-1:0]  data_cmd;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_req;
  logic [CMD_W-1:0]  mem_cmd;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;
  logic [2:0]        outstanding_o;
  logic              err_o;

  typedef struct packed {
    logic        instReq;
    logic        dataReq;
    logic        memAddrOk;
    logic        memDataOk;
    logic [31:0] memRdata;
  } inVec_t;

  // cmdSel: 0 = mem_cmd all zero, 1 = inst command, 2 = data command
  typedef struct packed {
    logic       memReq;
    logic [1:0] cmdSel;
    logic       instAddrOk;
    logic       dataAddrOk;
    logic       instDataOk;
    logic       dataDataOk;
    logic [2:0] outstanding;
    logic       err;
  } expVec_t;

  typedef struct packed {
    inVec_t  stim;
    expVec_t expd;
  } vecRec_t;

  vecRec_t tbl[$];
  int      applied     = 0;
  int      miscompares = 0;

  sram_like_arbiter #(
    .CMD_W      (CMD_W),
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_req      (inst_req),
    .inst_cmd      (inst_cmd),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .data_req      (data_req),
    .data_cmd      (data_cmd),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .mem_req       (mem_req),
    .mem_cmd       (mem_cmd),
    .mem_addr_ok   (mem_addr_ok),
    .mem_data_ok   (mem_data_ok),
    .mem_rdata     (mem_rdata),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build one vector record from its stimulus and expected outputs
  function automatic vecRec_t mk(input logic ir, input logic dr, input logic aok,
                                 input logic dok, input logic [31:0] rd,
                                 input logic mr, input logic [1:0] cs,
                                 input logic iao, input logic dao,
                                 input logic ido, input logic ddo,
                                 input logic [2:0] outs, input logic er);
    vecRec_t v;
    v.stim.instReq      = ir;
    v.stim.dataReq      = dr;
    v.stim.memAddrOk    = aok;
    v.stim.memDataOk    = dok;
    v.stim.memRdata     = rd;
    v.expd.memReq       = mr;
    v.expd.cmdSel       = cs;
    v.expd.instAddrOk   = iao;
    v.expd.dataAddrOk   = dao;
    v.expd.instDataOk   = ido;
    v.expd.dataDataOk   = ddo;
    v.expd.outstanding  = outs;
    v.expd.err          = er;
    return v;
  endfunction

  // Drive one cycle of inputs on the falling edge and let them settle
  task automatic applyStimulus(input inVec_t s);
    @(negedge clk);
    inst_req    = s.instReq;
    data_req    = s.dataReq;
    mem_addr_ok = s.memAddrOk;
    mem_data_ok = s.memDataOk;
    mem_rdata   = s.memRdata;
    #2;
  endtask

  // Compare every output against the expected record; one line per failure
  task automatic checkOutput(input string name, input inVec_t s, input expVec_t e);
    logic [CMD_W-1:0] expCmd;
    logic             ok;
    expCmd = (e.cmdSel == 2'd1) ? INST_CMD : (e.cmdSel == 2'd2) ? DATA_CMD : '0;
    applied++;
    ok = (mem_req === e.memReq) && (mem_cmd === expCmd) &&
         (inst_addr_ok === e.instAddrOk) && (data_addr_ok === e.dataAddrOk) &&
         (inst_data_ok === e.instDataOk) && (data_data_ok === e.dataDataOk) &&
         (outstanding_o === e.outstanding) && (err_o === e.err) &&
         (inst_rdata === s.memRdata) && (data_rdata === s.memRdata);
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL %s: got req=%b cmd=%h iaok=%b daok=%b idok=%b ddok=%b out=%0d err=%b ird=%h drd=%h | want req=%b cmd=%h iaok=%b daok=%b idok=%b ddok=%b out=%0d err=%b rd=%h",
               name, mem_req, mem_cmd, inst_addr_ok, data_addr_ok, inst_data_ok,
               data_data_ok, outstanding_o, err_o, inst_rdata, data_rdata,
               e.memReq, expCmd, e.instAddrOk, e.dataAddrOk, e.instDataOk,
               e.dataDataOk, e.outstanding, e.err, s.memRdata);
    end
  endtask

  task automatic runVec(input string name, input vecRec_t v);
    applyStimulus(v.stim);
    checkOutput(name, v.stim, v.expd);
  endtask

  // Hold rst_n low for the given number of rising edges with all requests idle
  task automatic doReset(input int cycles);
    @(negedge clk);
    rst_n       = 1'b0;
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    inst_req    = 1'b0;
    data_req    = 1'b0;
    inst_cmd    = INST_CMD;
    data_cmd    = DATA_CMD;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;

    // ir dr aok dok rdata | mr cs iao dao ido ddo out err
    // Inst alone, accepted at T0, answered at T2
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,          0, 2'd0, 0, 0, 0, 0, 3'd1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h1111_1111,  0, 2'd0, 0, 0, 1, 0, 3'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,          0, 2'd0, 0, 0, 0, 0, 3'd0, 0));
    // Both at T0: data first, inst next, responses in that order
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,          1, 2'd2, 0, 1, 0, 0, 3'd0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0, 3'd1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h2222_2222,  0, 2'd0, 0, 0, 0, 1, 3'd2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h3333_3333,  0, 2'd0, 0, 0, 1, 0, 3'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,          0, 2'd0, 0, 0, 0, 0, 3'd0, 0));
    // Inst locked for 3 stalled cycles while data_req rises
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,          1, 2'd1, 0, 0, 0, 0, 3'd0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,          1, 2'd1, 0, 0, 0, 0, 3'd0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,          1, 2'd1, 0, 0, 0, 0, 3'd0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0, 3'd0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,          1, 2'd2, 0, 1, 0, 0, 3'd1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h4444_4444,  0, 2'd0, 0, 0, 1, 0, 3'd2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h5555_5555,  0, 2'd0, 0, 0, 0, 1, 3'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,          0, 2'd0, 0, 0, 0, 0, 3'd0, 0));

    doReset(2);
    runVec("reset", mk(0, 0, 0, 0, 32'h0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      runVec($sformatf("tbl%0d", i), tbl[i]);
    end

    // Starvation: three data grants while inst waits, then inst is forced
    runVec("starve0", mk(1, 1, 1, 0, 32'h0,         1, 2'd2, 0, 1, 0, 0, 3'd1 - 3'd1, 0));
    runVec("starve1", mk(1, 1, 1, 1, 32'h6666_6666, 1, 2'd2, 0, 1, 0, 1, 3'd1, 0));
    runVec("starve2", mk(1, 1, 1, 1, 32'h7777_7777, 1, 2'd2, 0, 1, 0, 1, 3'd1, 0));
    runVec("starve3", mk(1, 1, 1, 1, 32'h8888_8888, 1, 2'd1, 1, 0, 0, 1, 3'd1, 0));
    runVec("starve4", mk(0, 0, 0, 1, 32'h9999_9999, 0, 2'd0, 0, 0, 1, 0, 3'd1, 0));
    runVec("starve5", mk(0, 0, 0, 0, 32'h0,         0, 2'd0, 0, 0, 0, 0, 3'd0, 0));

    // Fill the FIFO, block while full, free one slot, then drain
    runVec("full0", mk(0, 1, 1, 0, 32'h0,         1, 2'd2, 0, 1, 0, 0, 3'd0, 0));
    runVec("full1", mk(0, 1, 1, 0, 32'h0,         1, 2'd2, 0, 1, 0, 0, 3'd1, 0));
    runVec("full2", mk(0, 1, 1, 0, 32'h0,         1, 2'd2, 0, 1, 0, 0, 3'd2, 0));
    runVec("full3", mk(0, 1, 1, 0, 32'h0,         1, 2'd2, 0, 1, 0, 0, 3'd3, 0));
    runVec("full4", mk(1, 1, 1, 0, 32'h0,         0, 2'd0, 0, 0, 0, 0, 3'd4, 0));
    runVec("full5", mk(0, 1, 1, 1, 32'haaaa_aaaa, 0, 2'd0, 0, 0, 0, 1, 3'd4, 0));
    runVec("full6", mk(0, 1, 1, 0, 32'h0,         1, 2'd2, 0, 1, 0, 0, 3'd3, 0));
    runVec("drain0", mk(0, 0, 0, 1, 32'hb000_0000, 0, 2'd0, 0, 0, 0, 1, 3'd4, 0));
    runVec("drain1", mk(0, 0, 0, 1, 32'hb000_0001, 0, 2'd0, 0, 0, 0, 1, 3'd3, 0));
    runVec("drain2", mk(0, 0, 0, 1, 32'hb000_0002, 0, 2'd0, 0, 0, 0, 1, 3'd2, 0));
    runVec("drain3", mk(0, 0, 0, 1, 32'hb000_0003, 0, 2'd0, 0, 0, 0, 1, 3'd1, 0));
    runVec("drain4", mk(0, 0, 0, 0, 32'h0,         0, 2'd0, 0, 0, 0, 0, 3'd0, 0));

    // Spurious response sets the sticky error; reset clears it and drops a lock
    runVec("err0", mk(0, 0, 0, 1, 32'heeee_eeee, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0));
    runVec("err1", mk(0, 0, 0, 0, 32'h0,         0, 2'd0, 0, 0, 0, 0, 3'd0, 1));
    runVec("err2", mk(1, 0, 1, 0, 32'h0,         1, 2'd1, 1, 0, 0, 0, 3'd0, 1));
    runVec("err3", mk(1, 0, 0, 0, 32'h0,         1, 2'd1, 0, 0, 0, 0, 3'd1, 1));
    doReset(1);
    runVec("rst0", mk(0, 1, 1, 0, 32'h0,         1, 2'd2, 0, 1, 0, 0, 3'd0, 0));
    runVec("rst1", mk(0, 0, 0, 1, 32'hf0f0_f0f0, 0, 2'd0, 0, 0, 0, 1, 3'd1, 0));
    runVec("rst2", mk(0, 0, 0, 1, 32'hf1f1_f1f1, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0));
    runVec("rst3", mk(0, 0, 0, 0, 32'h0,         0, 2'd0, 0, 0, 0, 0, 3'd0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
